// File: rtl/id_stage_hs.sv
// id_stage_hs: decode front-end with 2-entry skid FIFO, load-use stall,
// MEM/WB operand forwarding and a valid/ready output register to EXE.
module id_stage_hs #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [31:0]      if_inst,
    input  logic             flush,
    input  logic             exe_ld_valid,
    input  logic [RA_W-1:0]  exe_ld_rd,
    input  logic             mem_fwd_we,
    input  logic [RA_W-1:0]  mem_fwd_addr,
    input  logic [XLEN-1:0]  mem_fwd_data,
    input  logic             wb_we,
    input  logic [RA_W-1:0]  wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    output logic [RA_W-1:0]  rf_rs1_addr,
    output logic [RA_W-1:0]  rf_rs2_addr,
    input  logic [XLEN-1:0]  rf_rs1_data,
    input  logic [XLEN-1:0]  rf_rs2_data,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [XLEN-1:0]  id_pc,
    output logic [31:0]      id_inst,
    output logic [RA_W-1:0]  id_rd,
    output logic [XLEN-1:0]  id_rs1_data,
    output logic [XLEN-1:0]  id_rs2_data,
    output logic             stall_flag,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    logic [XLEN-1:0] fifo_pc   [2];
    logic [31:0]     fifo_inst [2];
    logic [1:0]      count;
    logic            rd_ptr, wr_ptr;
    logic            head_valid, push, pop, ld;
    logic [31:0]     head_inst;
    logic [6:0]      head_op;
    logic [RA_W-1:0] head_rs1, head_rs2, held_rs1, held_rs2;
    logic            rs1_used, rs2_used, rs1_hz, rs2_hz, id_is_load;
    logic [XLEN-1:0] rs1_res, rs2_res, rs1_snoop, rs2_snoop;

    assign if_ready   = count != 2'd2;
    assign head_valid = count != 2'd0;
    assign head_inst  = fifo_inst[rd_ptr];
    assign head_op    = head_inst[6:0];
    assign head_rs1   = head_inst[15 +: RA_W];
    assign head_rs2   = head_inst[20 +: RA_W];
    assign held_rs1   = id_inst[15 +: RA_W];
    assign held_rs2   = id_inst[20 +: RA_W];
    assign rf_rs1_addr = head_rs1;
    assign rf_rs2_addr = head_rs2;

    assign rs1_used   = !(head_op == OP_LUI || head_op == OP_AUIPC || head_op == OP_JAL);
    assign rs2_used   = head_op == OP_OP || head_op == OP_STORE || head_op == OP_BRANCH;
    assign id_is_load = id_valid && id_inst[6:0] == OP_LOAD;
    // Second term catches a load still in the output register about to hand off to EXE.
    assign rs1_hz = rs1_used && head_rs1 != '0 &&
                    ((exe_ld_valid && exe_ld_rd == head_rs1) || (id_is_load && id_rd == head_rs1));
    assign rs2_hz = rs2_used && head_rs2 != '0 &&
                    ((exe_ld_valid && exe_ld_rd == head_rs2) || (id_is_load && id_rd == head_rs2));
    assign stall_flag = head_valid && (rs1_hz || rs2_hz);

    assign ld   = (!id_valid || id_ready) && head_valid && !stall_flag && !flush;
    assign push = if_valid && if_ready && !flush;
    assign pop  = ld;

    assign rs1_res = head_rs1 == '0 ? '0 :
                     mem_fwd_we && mem_fwd_addr == head_rs1 ? mem_fwd_data :
                     wb_we && wb_addr == head_rs1 ? wb_data : rf_rs1_data;
    assign rs2_res = head_rs2 == '0 ? '0 :
                     mem_fwd_we && mem_fwd_addr == head_rs2 ? mem_fwd_data :
                     wb_we && wb_addr == head_rs2 ? wb_data : rf_rs2_data;
    // A held instruction keeps picking up results that land while EXE is busy.
    assign rs1_snoop = held_rs1 != '0 && mem_fwd_we && mem_fwd_addr == held_rs1 ? mem_fwd_data :
                       held_rs1 != '0 && wb_we && wb_addr == held_rs1 ? wb_data : id_rs1_data;
    assign rs2_snoop = held_rs2 != '0 && mem_fwd_we && mem_fwd_addr == held_rs2 ? mem_fwd_data :
                       held_rs2 != '0 && wb_we && wb_addr == held_rs2 ? wb_data : id_rs2_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count        <= '0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            fifo_pc[0]   <= '0;
            fifo_pc[1]   <= '0;
            fifo_inst[0] <= '0;
            fifo_inst[1] <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]   <= if_pc;
                fifo_inst[wr_ptr] <= if_inst;
                wr_ptr            <= !wr_ptr;
            end
            if (pop) rd_ptr <= !rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_inst     <= '0;
            id_rd       <= '0;
            id_rs1_data <= '0;
            id_rs2_data <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (ld) begin
            id_valid    <= 1'b1;
            id_pc       <= fifo_pc[rd_ptr];
            id_inst     <= head_inst;
            id_rd       <= head_inst[7 +: RA_W];
            id_rs1_data <= rs1_res;
            id_rs2_data <= rs2_res;
        end else if (id_ready) begin
            id_valid <= 1'b0;
        end else if (id_valid) begin
            id_rs1_data <= rs1_snoop;
            id_rs2_data <= rs2_snoop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + CNT_W'(stall_flag && !(&stall_cnt));
            flush_cnt <= flush_cnt + CNT_W'(flush && !(&flush_cnt));
        end
    end
endmodule
